// File: rtl/gate_seq_pkg.sv
// Shared types and helpers for the gate vector sequencer.
package gate_seq_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // A 2-input gate has four truth-table rows.
  localparam int NUM_VECTORS = 4;

  // Index of the last truth-table row; reaching it ends the run.
  localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

  // Expected gate output for truth-table row idx ({a,b} == idx).
  function automatic logic expected_y(input logic [3:0] mask, input logic [1:0] idx);
    return mask[idx];
  endfunction

endpackage

// File: rtl/gate_seq_hold_timer.sv
// Hold-window timer: counts cycles while enabled, wraps after the last cycle
// of the window and flags that last cycle combinationally from its count.
module gate_seq_hold_timer #(
  parameter int HOLD_CYCLES = 10,
  parameter int CW          = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CW-1:0] hold_cnt_q;
  logic [CW-1:0] hold_cnt_d;
  logic          last_s;

  assign last_s = (hold_cnt_q == CW'(HOLD_CYCLES - 1));
  assign last   = last_s;

  // Next count: clear dominates, otherwise count and wrap at the window end.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (clr) begin
      hold_cnt_d = '0;
    end else if (en) begin
      if (last_s) begin
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + CW'(1);
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Truth-table stimulus and checker for a 2-input combinational gate.
// Drives {a,b} through 00,01,10,11, holds each row HOLD_CYCLES cycles,
// samples y on the last cycle of each hold and counts mismatches.
// Optional macro GATE_SEQ_FIRST_FAIL_EN adds first-mismatch capture outputs
// (fail_valid, fail_vec, fail_y).
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [3:0] TRUTH_MASK  = 4'b1000,
  parameter int         ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
`ifdef GATE_SEQ_FIRST_FAIL_EN
  ,
  output logic             fail_valid,
  output logic [1:0]       fail_vec,
  output logic             fail_y
`endif
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [1:0]       vec_idx_q, vec_idx_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             last_s;
  logic             start_accept_s;
  logic             mismatch_s;
  logic [1:0]       next_idx_s;

  // Start is honoured only when no run is in flight.
  assign start_accept_s = start && ((state_q == IDLE) || (state_q == DONE));
  assign next_idx_s     = vec_idx_q + 2'd1;

  // The hold counter only runs while driving; any other state keeps it at 0
  // so the first window after a start is a full HOLD_CYCLES long.
  gate_seq_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q != DRIVE),
    .en   (state_q == DRIVE),
    .last (last_s)
  );

  // Next-state and next-output logic for the run sequencer.
  always_comb begin
    state_d    = state_q;
    vec_idx_d  = vec_idx_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    mismatch_s = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_accept_s) begin
          state_d   = DRIVE;
          vec_idx_d = 2'd0;
          a_d       = 1'b0;
          b_d       = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
        end else begin
          state_d = state_q;
        end
      end
      DRIVE: begin
        if (last_s) begin
          // y has had the whole window to settle; sample it now.
          mismatch_s = (y != expected_y(TRUTH_MASK, vec_idx_q));
          if (mismatch_s && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
          end else begin
            err_d = err_q;
          end
          if (vec_idx_q != LAST_VEC) begin
            vec_idx_d = next_idx_s;
            a_d       = next_idx_s[1];
            b_d       = next_idx_s[0];
          end else begin
            state_d   = DONE;
            vec_idx_d = 2'd0;
            a_d       = 1'b0;
            b_d       = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = (err_d == '0);
          end
        end else begin
          state_d = DRIVE;
        end
      end
      default: begin
        state_d   = IDLE;
        vec_idx_d = 2'd0;
        a_d       = 1'b0;
        b_d       = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        pass_d    = 1'b0;
        err_d     = '0;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset abandons any run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_idx_q <= 2'd0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_idx   = vec_idx_q;

`ifdef GATE_SEQ_FIRST_FAIL_EN
  logic       fail_valid_q, fail_valid_d;
  logic [1:0] fail_vec_q, fail_vec_d;
  logic       fail_y_q, fail_y_d;

  // Capture the first mismatch of a run; a new start wipes the record.
  always_comb begin
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_y_d     = fail_y_q;
    if (start_accept_s) begin
      fail_valid_d = 1'b0;
      fail_vec_d   = 2'd0;
      fail_y_d     = 1'b0;
    end else if (mismatch_s && !fail_valid_q) begin
      fail_valid_d = 1'b1;
      fail_vec_d   = vec_idx_q;
      fail_y_d     = y;
    end else begin
      fail_valid_d = fail_valid_q;
    end
  end

  // First-fail record registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'd0;
      fail_y_q     <= 1'b0;
    end else begin
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_y_q     <= fail_y_d;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_y     = fail_y_q;
`endif

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
- Self-checking stimulus stage for 2-input combinational gate DUTs (and_gate and siblings).
- Drives `a`/`b` through the full truth table 00, 01, 10, 11, holding each vector a programmable number of cycles.
- Samples the DUT output `y` at the end of each hold window and compares it against an expected truth-table mask.
- Reports mismatch count and pass/done status. Sits directly upstream of the gate (feeds it) and consumes its `y`.

Parameters:
- HOLD_CYCLES, 10, cycles each vector is held; legal range ≥1.
- TRUTH_MASK, 4'b1000, expected `y` per vector index; bit i is the expected output for {a,b}=i. Default is AND.
- ERR_W, 4, width of the mismatch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  run request; sampled in IDLE or DONE only.
- a  out  1  DUT input a; registered.
- b  out  1  DUT input b; registered.
- y  in  1  DUT output; treated as combinational from `a`/`b`.
- busy  out  1  high while vectors are being driven.
- done  out  1  high in DONE until the next start.
- pass  out  1  `done` && `err_count`==0.
- err_count  out  ERR_W  mismatch count; saturates at all-ones.
- vec_idx  out  2  current vector index; {a,b}==vec_idx while busy.

Behaviour:
- Reset: one clock with rst_n=0 forces state IDLE. All of the following go to 0: a, b, busy, done, pass, err_count, vec_idx, hold_cnt. Reset applies in any state, including mid-run; the run is abandoned with no partial result.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 → next cycle DRIVE, vec_idx=0, hold_cnt=0, a=0, b=0, err_count=0, busy=1.
- DRIVE:
  - hold_cnt increments each cycle.
  - When hold_cnt==HOLD_CYCLES-1: compare y against TRUTH_MASK[vec_idx]. On mismatch, err_count+1, saturating.
  - After that compare, if vec_idx<3: vec_idx+1, hold_cnt=0, a/b take the new index next cycle.
  - After that compare, if vec_idx==3: next cycle DONE, busy=0, done=1, a=b=0.
- Run length: 4×HOLD_CYCLES cycles of busy. Example: HOLD_CYCLES=1 gives one cycle per vector.
- DONE:
  - err_count, done and pass are held.
  - start=1 → restart exactly as from IDLE: err_count is cleared, done drops the same cycle busy rises.
- start while DRIVE: ignored, no restart.
- y is sampled only on compare cycles; other cycles are don't-care (DUT settle time).
- Simultaneous compare mismatch and saturation: err_count stays at all-ones.

Optional Feature:
- Macro GATE_SEQ_FIRST_FAIL_EN.
- When defined, adds three outputs:
  - fail_valid (1): set on the first mismatch of a run, held until restart or reset.
  - fail_vec (2): vec_idx at that first mismatch, frozen afterwards.
  - fail_y (1): observed y at that first mismatch, frozen afterwards.
- These outputs clear to 0 on reset and on start.
- When undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package gate_seq_pkg holds:
  - state enum {IDLE, DRIVE, DONE}.
  - constant NUM_VECTORS=4.
  - function expected_y(mask, idx).
- One natural sub-module: gate_seq_hold_timer.
  - Counter with clear/enable and a last-cycle flag at HOLD_CYCLES-1.
  - Uses the same clk and rst_n.

Test Plan:
- AND model on y, HOLD_CYCLES=10, one-cycle start pulse → busy for exactly 40 cycles; {a,b} sequence 00,01,10,11 with 10 cycles each; then done=1, err_count=0, pass=1.
- OR model on y with TRUTH_MASK=4'b1000 → mismatches at idx 1 and 2; err_count=2, pass=0, done=1.
- y stuck at 1, ERR_W=1 → err_count saturates at 1 after idx 0 and stays 1; pass=0.
- rst_n=0 at cycle 15 of a run → next cycle all outputs 0, state IDLE. Separately, start re-pulsed during busy → no restart, run completes at cycle 40.
- HOLD_CYCLES=1, AND model → busy exactly 4 cycles, {a,b} changes every cycle; a second start in DONE clears err_count and reruns.
- With GATE_SEQ_FIRST_FAIL_EN and y stuck at 0 against the AND mask → fail_valid=1, fail_vec=3, fail_y=0, err_count=1.
